ssd_scan_scheduler: RTL and testbench
=====================================

SSD_SCAN_SCHEDULER -- requirements
Module: ssd_scan_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 262144, meaning clocks each digit is driven (2.62 ms at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1024, meaning clocks all anodes are off before each digit (anti-ghosting).
REQ-003 SHALL have port ClkPort, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port load_valid, input, 1, producer offers a new display word.
REQ-006 SHALL have port load_ready, output, 1, the block can accept a word.
REQ-007 SHALL have port load_data, input, 32, eight hex nibbles; nibble i is [4i+3:4i] for digit i.
REQ-008 SHALL have port load_dp, input, 8, decimal point per digit (1 = lit).
REQ-009 SHALL have port enable_mask, input, 8, digit i is lit only when bit i = 1; sampled live.
REQ-010 SHALL have port An, output, 8, active-low anodes; An[i] selects digit i.
REQ-011 SHALL have port Cathodes, output, 8, active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of every 8-digit frame.

Function
REQ-013 SHALL use a two-state FSM, BLANK and DRIVE, plus a 3-bit digit index and a dwell counter.
REQ-014 In BLANK: An = 8'hFF and Cathodes = 8'hFF for exactly BLANK_CYCLES clocks, then the FSM enters DRIVE.
REQ-015 In DRIVE: An[idx] = ~enable_mask[idx] with all other anodes 1, for exactly DWELL_CYCLES clocks; the FSM then enters BLANK with idx+1, and 7 wraps to 0.
REQ-016 Frame length SHALL be 8*(BLANK_CYCLES+DWELL_CYCLES) clocks regardless of enable_mask; a masked digit keeps its time slot.
REQ-017 In DRIVE, Cathodes[7:1] SHALL be the hex-to-segment code of active nibble idx, and Cathodes[0] = ~active_dp[idx].
REQ-018 Segment codes, abcdefg active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
REQ-019 An and Cathodes SHALL be registered, changing only on a clock edge, with one cycle of latency from FSM state/index.
REQ-020 Handshake: one pending register; load_ready = ~pending_valid; a transfer occurs when load_valid & load_ready are high on the same edge and captures load_data/load_dp into pending.
REQ-021 Commit: on the last DRIVE cycle of digit 7, frame_done = 1 and, if pending_valid, pending moves to active and pending_valid clears; the display never changes mid-frame.
REQ-022 A transfer accepted on the commit edge (pending empty) SHALL go to pending and commit at the next frame end.
REQ-023 load_valid held with load_ready low SHALL cause no state change; the producer holds its data.

Reset
REQ-024 With Reset_n = 0 at a clock edge: state = BLANK, idx = 0, counter = 0, An = 8'hFF, Cathodes = 8'hFF, frame_done = 0, pending_valid = 0 (load_ready = 1), active data = 0, active_dp = 0.
REQ-025 Reset mid-frame SHALL discard the pending word; scanning restarts at digit 0 BLANK after Reset_n returns to 1.

Configuration
REQ-026 Macro SSD_ZERO_BLANK_EN defined: in DRIVE, digit i (i>0) SHALL show Cathodes = 8'hFF when nibble i and all higher nibbles are 0 and active_dp[i] = 0; digit 0 is always shown.
REQ-027 Macro undefined: every enabled digit SHALL show its nibble, including leading zeros.

Structure
REQ-028 Package ssd_pkg SHALL hold the FSM state enum, NUM_DIGITS = 8, and the 16-entry segment code table.
REQ-029 Sub-module ssd_hex_decode (4-bit nibble to 7-bit segments, combinational) SHALL be instantiated once.

Verification (DWELL_CYCLES = 4, BLANK_CYCLES = 2)
REQ-030 After reset: An = FF for 2 clocks, then An = FE for 4 clocks, then FF, then FD; frame_done pulses every 48 clocks.
REQ-031 Load 32'h0000_1234 with dp = 8'h04 mid-frame: no change until frame_done; next frame digit 0 Cathodes = 8'h99 (4), digit 2 Cathodes = 8'h24 (2 with Dp lit).
REQ-032 Two back-to-back loads: second sees load_ready = 0 until commit; first word displays, then second displays one frame later.
REQ-033 enable_mask = 8'h01: only the digit 0 slot drives An = FE; frame length stays 48 clocks.
REQ-034 SSD_ZERO_BLANK_EN defined with data 32'h0000_0050: digits 2-7 show Cathodes = FF; digit 1 shows 8'h49 (5); digit 0 shows 8'h03 (0).
REQ-035 Reset_n = 0 during digit-5 DRIVE with a pending word: An = FF next cycle, load_ready = 1, and the pending word is never displayed.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_pkg
//  Description : Shared types and constants for the seven-segment scan
//                scheduler: scan FSM state, digit count, hex segment table.
//  Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  // Number of multiplexed digits on the display
  localparam int NUM_DIGITS = 8;

  // Scan FSM: all anodes off (anti-ghosting) or one digit driven
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low segment codes, bit order {a,b,c,d,e,f,g}, indexed by nibble
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // D
    7'b0110001,  // C
    7'b1100000,  // B
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Table lookup kept as a function so callers never index the constant
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_hex_decode
//  Description : Combinational 4-bit hex nibble to active-low 7-segment
//                pattern {a,b,c,d,e,f,g}.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup, no state
  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_scheduler
//  Description : Eight-digit multiplexed seven-segment scan scheduler.
//                Each digit slot is BLANK_CYCLES of all-off followed by
//                DWELL_CYCLES of drive. A new display word is taken through a
//                single-entry valid/ready buffer and only becomes visible at
//                a frame boundary, so a frame never mixes two words.
//                Optional build macro SSD_ZERO_BLANK_EN: suppress leading
//                zero digits (digit 0 always shown).
//  Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_scheduler
  import ssd_pkg::*;
#(
  parameter int DWELL_CYCLES = 262144,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic        ClkPort,
  input  logic        Reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  enable_mask,
  output logic [7:0]  An,
  output logic [7:0]  Cathodes,
  output logic        frame_done
);

  // One counter serves both phases, so it is sized for the longer one
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  // Scan FSM state
  scan_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_end_w;

  // Load buffer and the word currently on display
  logic             pend_valid_q;
  logic [31:0]      pend_data_q;
  logic [7:0]       pend_dp_q;
  logic [31:0]      active_data_q;
  logic [7:0]       active_dp_q;

  // Registered pin drive
  logic [7:0]       an_d, an_q;
  logic [7:0]       cath_d, cath_q;

  // Segment decode of the selected nibble
  logic [3:0]       nibble_w;
  logic [6:0]       seg_w;

  assign nibble_w = active_data_q[{idx_q, 2'b00} +: 4];

  ssd_hex_decode u_hex_decode (
    .nibble_i (nibble_w),
    .seg_o    (seg_w)
  );

`ifdef SSD_ZERO_BLANK_EN
  // upper_zero_w[i]: nibble i and every nibble above it are zero
  logic [NUM_DIGITS-1:0] upper_zero_w;
  logic                  lead_blank_w;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
    assign upper_zero_w[gi] = ~|active_data_q[31:4*gi];
  end

  assign lead_blank_w = (idx_q != 3'd0) && upper_zero_w[idx_q] && !active_dp_q[idx_q];
`endif

  // FSM state register: phase, digit index and phase cycle counter
  always_ff @(posedge ClkPort) begin
    if (!Reset_n) begin
      state_q <= ST_BLANK;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: count out each phase, advance digit after its dwell
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: next anode/cathode pattern and the frame-end strobe
  always_comb begin
    an_d        = 8'hFF;
    cath_d      = 8'hFF;
    frame_end_w = (state_q == ST_DRIVE) && (idx_q == LAST_DIGIT) && (cnt_q == DWELL_LAST);
    if (state_q == ST_DRIVE) begin
      // A masked digit keeps its slot but its anode stays off
      an_d[idx_q] = ~enable_mask[idx_q];
      cath_d      = {seg_w, ~active_dp_q[idx_q]};
`ifdef SSD_ZERO_BLANK_EN
      if (lead_blank_w) begin
        cath_d = 8'hFF;
      end
`endif
    end
  end

  // Pin drive registers, one cycle behind the FSM
  always_ff @(posedge ClkPort) begin
    if (!Reset_n) begin
      an_q   <= 8'hFF;
      cath_q <= 8'hFF;
    end else begin
      an_q   <= an_d;
      cath_q <= cath_d;
    end
  end

  // Load buffer: accept when empty, hand over to display at frame end
  always_ff @(posedge ClkPort) begin
    if (!Reset_n) begin
      pend_valid_q  <= 1'b0;
      pend_data_q   <= 32'h0;
      pend_dp_q     <= 8'h0;
      active_data_q <= 32'h0;
      active_dp_q   <= 8'h0;
    end else if (frame_end_w && pend_valid_q) begin
      active_data_q <= pend_data_q;
      active_dp_q   <= pend_dp_q;
      pend_valid_q  <= 1'b0;
    end else if (load_valid && !pend_valid_q) begin
      // Buffer empty (also on the frame-end edge): word waits for next frame
      pend_data_q  <= load_data;
      pend_dp_q    <= load_dp;
      pend_valid_q <= 1'b1;
    end
  end

  assign load_ready = ~pend_valid_q;
  assign An         = an_q;
  assign Cathodes   = cath_q;
  assign frame_done = frame_end_w;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_scan_scheduler
//  Description : Self-checking bench for ssd_scan_scheduler with
//                DWELL_CYCLES = 4, BLANK_CYCLES = 2 (48-clock frame).
//                Honours SSD_ZERO_BLANK_EN in its expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_scheduler;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = 8 * SLOT;

  logic        clk;
  logic        Reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [7:0]  enable_mask;
  logic [7:0]  An;
  logic [7:0]  Cathodes;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  ssd_scan_scheduler #(
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .ClkPort     (clk),
    .Reset_n     (Reset_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .enable_mask (enable_mask),
    .An          (An),
    .Cathodes    (Cathodes),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment patterns {a..g}, active low
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b0000001;
      4'h1: seg_of = 7'b1001111;
      4'h2: seg_of = 7'b0010010;
      4'h3: seg_of = 7'b0000110;
      4'h4: seg_of = 7'b1001100;
      4'h5: seg_of = 7'b0100100;
      4'h6: seg_of = 7'b0100000;
      4'h7: seg_of = 7'b0001111;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0000100;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b1100000;
      4'hC: seg_of = 7'b0110001;
      4'hD: seg_of = 7'b1000010;
      4'hE: seg_of = 7'b0110000;
      default: seg_of = 7'b0111000;
    endcase
  endfunction

  // Cathode pattern that digit d must show for a displayed word
  function automatic logic [7:0] cath_of(input logic [31:0] w, input logic [7:0] dp, input int d);
    logic [31:0] up;
    up = w >> (4 * d);
    cath_of = {seg_of(up[3:0]), ~dp[d]};
`ifdef SSD_ZERO_BLANK_EN
    if (d > 0 && up == 32'h0 && !dp[d]) cath_of = 8'hFF;
`endif
  endfunction

  // Reference model: frame position is plain cycle arithmetic since reset
  logic        m_live = 1'b0;
  int          m_pos  = 0;
  logic        m_pv   = 1'b0;
  logic [31:0] m_pd   = 32'h0;
  logic [7:0]  m_pdp  = 8'h0;
  logic [31:0] m_ad   = 32'h0;
  logic [7:0]  m_adp  = 8'h0;

  initial begin : model
    int p;
    int d;
    logic [7:0] e_an;
    logic [7:0] e_ca;
    logic       e_fd;
    logic       e_rdy;
    e_an = 8'hFF;
    e_ca = 8'hFF;
    forever begin
      @(posedge clk);
      if (!Reset_n) begin
        m_live = 1'b1;
        m_pos  = 0;
        m_pv   = 1'b0;
        m_pd   = 32'h0;
        m_pdp  = 8'h0;
        m_ad   = 32'h0;
        m_adp  = 8'h0;
        e_an   = 8'hFF;
        e_ca   = 8'hFF;
      end else if (m_live) begin
        p = m_pos;
        d = p / SLOT;
        if ((p % SLOT) < BLANK) begin
          e_an = 8'hFF;
          e_ca = 8'hFF;
        end else begin
          e_an    = 8'hFF;
          e_an[d] = ~enable_mask[d];
          e_ca    = cath_of(m_ad, m_adp, d);
        end
        if (p == FRAME - 1 && m_pv) begin
          m_ad  = m_pd;
          m_adp = m_pdp;
          m_pv  = 1'b0;
        end else if (load_valid && !m_pv) begin
          m_pd  = load_data;
          m_pdp = load_dp;
          m_pv  = 1'b1;
        end
        m_pos = (p + 1) % FRAME;
      end
      e_fd  = (m_pos == FRAME - 1);
      e_rdy = !m_pv;
      #1;
      if (m_live) begin
        chk("model_an",    32'(An),         32'(e_an));
        chk("model_cath",  32'(Cathodes),   32'(e_ca));
        chk("model_fd",    32'(frame_done), 32'(e_fd));
        chk("model_ready", 32'(load_ready), 32'(e_rdy));
      end
    end
  end

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) begin
      total++;
      bad++;
      $display("FAIL fd_timeout: got no pulse want pulse within 200 cycles");
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] p, output int waited);
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = p;
    waited     = 0;
    while (!load_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!load_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 within 200 cycles");
    end
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  logic [7:0] exp_an_seq [9] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFD};

  initial begin : stim
    int w;
    int n_lit;
    int n_fe;
    int n_fd;
    logic [7:0] exp_lead;
    Reset_n     = 1'b0;
    load_valid  = 1'b0;
    load_data   = 32'h0;
    load_dp     = 8'h0;
    enable_mask = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_an",    32'(An),         32'hFF);
    chk("rst_cath",  32'(Cathodes),   32'hFF);
    chk("rst_ready", 32'(load_ready), 32'h1);
    chk("rst_fd",    32'(frame_done), 32'h0);
    Reset_n = 1'b1;

    // Slot timing of the first two digits
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("an_seq", 32'(An), 32'(exp_an_seq[i]));
    end
    wait_fd(w);
    chk("fd_first", 32'(w), 32'd38);
    wait_fd(w);
    chk("fd_period", 32'(w), 32'd48);

    // Mid-frame load shows up only after the frame boundary
    repeat (10) @(negedge clk);
    send(32'h0000_1234, 8'h04, w);
    chk("ready_pending", 32'(load_ready), 32'h0);
    wait_fd(w);
    repeat (4) @(negedge clk);
    chk("d0_an",   32'(An),       32'hFE);
    chk("d0_four", 32'(Cathodes), 32'h99);
    repeat (6) @(negedge clk);
    chk("d1_three", 32'(Cathodes), 32'h0D);
    repeat (6) @(negedge clk);
    chk("d2_two_dp", 32'(Cathodes), 32'h24);

    // Back-to-back loads: second waits for the commit of the first
    wait_fd(w);
    repeat (10) @(negedge clk);
    send(32'h0000_00C5, 8'h00, w);
    send(32'h8765_4321, 8'h00, w);
    chk("b2b_wait", 32'(w), 32'd38);
    repeat (2) @(negedge clk);
    chk("b2b_first", 32'(Cathodes), 32'h49);
    wait_fd(w);
    repeat (4) @(negedge clk);
    chk("b2b_second_d0", 32'(Cathodes), 32'h9F);
    repeat (6) @(negedge clk);
    chk("b2b_second_d1", 32'(Cathodes), 32'h25);

    // Only digit 0 enabled: slot structure unchanged
    enable_mask = 8'h01;
    wait_fd(w);
    n_lit = 0;
    n_fe  = 0;
    n_fd  = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (An != 8'hFF) n_lit++;
      if (An == 8'hFE) n_fe++;
      if (frame_done) n_fd++;
    end
    chk("mask_lit",  32'(n_lit), 32'd4);
    chk("mask_fe",   32'(n_fe),  32'd4);
    chk("mask_fd",   32'(n_fd),  32'd1);
    enable_mask = 8'hFF;

    // Leading zeros; load offered exactly on the commit edge
    send(32'h0000_0050, 8'h00, w);
    wait_fd(w);
    repeat (4) @(negedge clk);
    chk("lz_d0", 32'(Cathodes), 32'h03);
    repeat (6) @(negedge clk);
    chk("lz_d1", 32'(Cathodes), 32'h49);
    repeat (6) @(negedge clk);
`ifdef SSD_ZERO_BLANK_EN
    exp_lead = 8'hFF;
`else
    exp_lead = 8'h03;
`endif
    chk("lz_d2", 32'(Cathodes), 32'(exp_lead));

    // Reset during digit 5 with a word pending
    send(32'h9999_9999, 8'hFF, w);
    w = 0;
    while (An != 8'hDF && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("d5_reached", 32'(An), 32'hDF);
    Reset_n = 1'b0;
    @(negedge clk);
    chk("rst5_an",    32'(An),         32'hFF);
    chk("rst5_ready", 32'(load_ready), 32'h1);
    Reset_n = 1'b1;
    wait_fd(w);
    chk("rst5_fd", 32'(w), 32'd47);
    repeat (4) @(negedge clk);
    chk("rst5_d0_zero", 32'(Cathodes), 32'h03);
    wait_fd(w);
    repeat (4) @(negedge clk);
    chk("rst5_d0_still_zero", 32'(Cathodes), 32'h03);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish want finish before 600000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
